// File: rtl/rv32i_types.sv
// Shared types for the CPU-side memory port arbiter: FSM state encoding and
// the latched downstream request record.
package rv32i_types;

  localparam int ARB_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [ARB_WIDTH-1:0]   addr;
    logic [ARB_WIDTH-1:0]   wdata;
    logic [ARB_WIDTH/8-1:0] byte_enable;
  } arb_req_t;

  // Saturating increment used by the fetch-starvation streak counter.
  function automatic int sat_inc(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and the LSQ.
// Data side wins by default; a streak counter forces a fetch grant after STARVE_LIMIT D grants.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int WIDTH        = ARB_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [WIDTH-1:0]   i_mem_address,
  output logic               i_mem_resp,
  output logic [WIDTH-1:0]   i_mem_rdata,

  input  logic               lsq_mem_read,
  input  logic               lsq_mem_write,
  input  logic [WIDTH-1:0]   lsq_mem_address,
  input  logic [WIDTH-1:0]   lsq_mem_wdata,
  input  logic [WIDTH/8-1:0] lsq_mem_byte_enable,
  output logic               lsq_mem_resp,
  output logic [WIDTH-1:0]   lsq_mem_rdata,

  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_address,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  input  logic               mem_resp,
  input  logic [WIDTH-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t      state_reg, state_next;
  logic [SW-1:0]   streak_reg, streak_next;
  arb_req_t        req_reg, req_next;
  logic            d_req;
  logic            i_req;

  assign d_req = lsq_mem_read | lsq_mem_write;
  assign i_req = i_mem_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ARB_IDLE;
      streak_reg <= '0;
      req_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      req_reg    <= req_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    streak_next  = streak_reg;
    req_next     = req_reg;
    i_mem_resp   = 1'b0;
    lsq_mem_resp = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (d_req && (!i_req || streak_reg < LIMIT)) begin
          state_next  = ARB_SERVE_D;
          req_next    = '{read:        lsq_mem_read,
                          write:       lsq_mem_write,
                          addr:        lsq_mem_address,
                          wdata:       lsq_mem_wdata,
                          byte_enable: lsq_mem_byte_enable};
          streak_next = i_req ? SW'(sat_inc(int'(streak_reg), STARVE_LIMIT)) : '0;
        end else if (i_req) begin
          state_next  = ARB_SERVE_I;
          req_next    = '{read:        1'b1,
                          write:       1'b0,
                          addr:        i_mem_address,
                          wdata:       '0,
                          byte_enable: '1};
          streak_next = '0;
        end else begin
          streak_next = '0;
        end
      end

      ARB_SERVE_I: begin
        if (mem_resp) begin
          i_mem_resp     = 1'b1;
          req_next.read  = 1'b0;
          req_next.write = 1'b0;
          state_next     = ARB_IDLE;
        end
      end

      ARB_SERVE_D: begin
        if (mem_resp) begin
          lsq_mem_resp   = 1'b1;
          req_next.read  = 1'b0;
          req_next.write = 1'b0;
          state_next     = ARB_IDLE;
        end
      end

      default: state_next = ARB_IDLE;
    endcase
  end

  // Downstream request comes straight from the latch, so it is stable for the whole serve.
  assign mem_read        = req_reg.read;
  assign mem_write       = req_reg.write;
  assign mem_address     = req_reg.addr;
  assign mem_wdata       = req_reg.wdata;
  assign mem_byte_enable = req_reg.byte_enable;

  assign i_mem_rdata   = mem_rdata;
  assign lsq_mem_rdata = mem_rdata;

  a_lsq_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(lsq_mem_read && lsq_mem_write));

  a_fetch_read_only: assert property (@(posedge clk) disable iff (!rst)
    !i_mem_write);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/starvation/hold sequences, and a randomized run against an ownership-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_read, i_mem_write;
  logic [31:0] i_mem_address;
  logic        i_mem_resp;
  logic [31:0] i_mem_rdata;
  logic        lsq_mem_read, lsq_mem_write;
  logic [31:0] lsq_mem_address, lsq_mem_wdata;
  logic [3:0]  lsq_mem_byte_enable;
  logic        lsq_mem_resp;
  logic [31:0] lsq_mem_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_mem_read          (i_mem_read),
    .i_mem_write         (i_mem_write),
    .i_mem_address       (i_mem_address),
    .i_mem_resp          (i_mem_resp),
    .i_mem_rdata         (i_mem_rdata),
    .lsq_mem_read        (lsq_mem_read),
    .lsq_mem_write       (lsq_mem_write),
    .lsq_mem_address     (lsq_mem_address),
    .lsq_mem_wdata       (lsq_mem_wdata),
    .lsq_mem_byte_enable (lsq_mem_byte_enable),
    .lsq_mem_resp        (lsq_mem_resp),
    .lsq_mem_rdata       (lsq_mem_rdata),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_address         (mem_address),
    .mem_wdata           (mem_wdata),
    .mem_byte_enable     (mem_byte_enable),
    .mem_resp            (mem_resp),
    .mem_rdata           (mem_rdata)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive_idle();
    i_mem_read = 0; i_mem_write = 0; i_mem_address = '0;
    lsq_mem_read = 0; lsq_mem_write = 0; lsq_mem_address = '0;
    lsq_mem_wdata = '0; lsq_mem_byte_enable = '0;
    mem_resp = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        i_rd;
    logic [31:0] i_addr;
    logic        l_rd, l_wr;
    logic [31:0] l_addr, l_wdata;
    logic [3:0]  l_be;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_iresp, e_lresp;
  } vec_t;

  vec_t vecs[13];

  // ownership-level reference model: 0 = nobody, 1 = fetch, 2 = LSQ
  int          m_owner;
  int          m_streak;
  logic        m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  initial begin
    // I-only, then simultaneous (D first, I after one idle), then spurious resp
    vecs[0]  = '{1, 32'h60, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 0, 0};
    vecs[1]  = '{1, 32'h60, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        1, 0, 32'h60,   32'h0,        4'hF, 0, 0};
    vecs[2]  = '{1, 32'h60, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h00A00093, 1, 0, 32'h60,   32'h0,        4'hF, 1, 0};
    vecs[3]  = '{0, 32'h60, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        0, 0, 32'h60,   32'h0,        4'hF, 0, 0};
    vecs[4]  = '{1, 32'h64, 0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 32'h0,        0, 0, 32'h60,   32'h0,        4'hF,    0, 0};
    vecs[5]  = '{1, 32'h64, 0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 32'h0,        0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 0};
    vecs[6]  = '{1, 32'h64, 0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 1, 32'h12345678, 0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 1};
    vecs[7]  = '{1, 32'h64, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        0, 0, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 0};
    vecs[8]  = '{1, 32'h64, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        1, 0, 32'h64,   32'h0,        4'hF, 0, 0};
    vecs[9]  = '{1, 32'h64, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1, 0, 32'h64,   32'h0,        4'hF, 1, 0};
    vecs[10] = '{0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        0, 0, 32'h64,   32'h0,        4'hF, 0, 0};
    vecs[11] = '{0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h55AA55AA, 0, 0, 32'h64,   32'h0,        4'hF, 0, 0};
    vecs[12] = '{0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,        0, 0, 32'h64,   32'h0,        4'hF, 0, 0};

    do_reset();
    #1;
    chk("reset_mem_read",  mem_read,  0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_addr",  mem_address, 0);
    chk("reset_be",        mem_byte_enable, 0);
    chk("reset_i_resp",    i_mem_resp, 0);
    chk("reset_lsq_resp",  lsq_mem_resp, 0);

    // ---------------- directed table ----------------
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      i_mem_read          = vecs[v].i_rd;
      i_mem_address       = vecs[v].i_addr;
      lsq_mem_read        = vecs[v].l_rd;
      lsq_mem_write       = vecs[v].l_wr;
      lsq_mem_address     = vecs[v].l_addr;
      lsq_mem_wdata       = vecs[v].l_wdata;
      lsq_mem_byte_enable = vecs[v].l_be;
      mem_resp            = vecs[v].m_resp;
      mem_rdata           = vecs[v].m_rdata;
      #1;
      chk($sformatf("vec%0d_mem_read", v),  mem_read,        vecs[v].e_rd);
      chk($sformatf("vec%0d_mem_write", v), mem_write,       vecs[v].e_wr);
      chk($sformatf("vec%0d_mem_addr", v),  mem_address,     vecs[v].e_addr);
      chk($sformatf("vec%0d_mem_wdata", v), mem_wdata,       vecs[v].e_wdata);
      chk($sformatf("vec%0d_mem_be", v),    mem_byte_enable, vecs[v].e_be);
      chk($sformatf("vec%0d_i_resp", v),    i_mem_resp,      vecs[v].e_iresp);
      chk($sformatf("vec%0d_lsq_resp", v),  lsq_mem_resp,    vecs[v].e_lresp);
      chk($sformatf("vec%0d_i_rdata", v),   i_mem_rdata,     vecs[v].m_rdata);
      chk($sformatf("vec%0d_lsq_rdata", v), lsq_mem_rdata,   vecs[v].m_rdata);
      $display("vec %0d: mem_rd=%0b mem_wr=%0b addr=0x%08h i_resp=%0b lsq_resp=%0b",
               v, mem_read, mem_write, mem_address, i_mem_resp, lsq_mem_resp);
    end

    // ---------------- reset in the middle of SERVE_D ----------------
    do_reset();
    lsq_mem_write = 1; lsq_mem_address = 32'h40; lsq_mem_wdata = 32'h11; lsq_mem_byte_enable = 4'hF;
    @(negedge clk);
    #1;
    chk("rst_mid_serving", mem_write, 1);
    @(negedge clk);
    mem_resp = 1; mem_rdata = 32'h77;
    rst = 0;
    #1;
    chk("rst_mid_mem_write", mem_write, 0);
    chk("rst_mid_mem_read",  mem_read, 0);
    chk("rst_mid_lsq_resp",  lsq_mem_resp, 0);
    chk("rst_mid_i_resp",    i_mem_resp, 0);
    $display("reset mid-serve: mem_wr=%0b lsq_resp=%0b", mem_write, lsq_mem_resp);
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst_after_idle", mem_write, 0);

    // ---------------- starvation ----------------
    do_reset();
    begin
      int          ng;
      logic [31:0] owners [10];
      ng = 0;
      i_mem_read = 1; i_mem_address = 32'h80;
      lsq_mem_read = 1; lsq_mem_address = 32'h2000;
      for (int c = 0; c < 80 && ng < 10; c++) begin
        @(negedge clk);
        mem_resp  = mem_read;
        mem_rdata = 32'(c);
        #1;
        if (mem_resp) begin
          owners[ng] = mem_address;
          chk($sformatf("starve%0d_lsq_resp", ng), lsq_mem_resp, (mem_address == 32'h2000) ? 1 : 0);
          chk($sformatf("starve%0d_i_resp", ng),   i_mem_resp,   (mem_address == 32'h80) ? 1 : 0);
          $display("starvation grant %0d -> addr 0x%08h", ng, mem_address);
          ng++;
        end
      end
      chk("starve_grant_count", 32'(ng), 32'd10);
      for (int k = 0; k < ng; k++)
        chk($sformatf("starve_owner%0d", k), owners[k], (k == 4 || k == 9) ? 32'h80 : 32'h2000);
    end
    @(negedge clk);
    drive_idle();

    // ---------------- hold: address latched while waiting ----------------
    do_reset();
    i_mem_read = 1; i_mem_address = 32'h300;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_mem_address = 32'h400 + 32'(k * 4);
      #1;
      chk($sformatf("hold%0d_addr", k), mem_address, 32'h300);
      chk($sformatf("hold%0d_read", k), mem_read, 1);
    end
    @(negedge clk);
    mem_resp = 1; mem_rdata = 32'hABCD0123;
    #1;
    chk("hold_resp",      i_mem_resp, 1);
    chk("hold_resp_addr", mem_address, 32'h300);
    $display("hold: addr stayed 0x%08h, i_resp=%0b", mem_address, i_mem_resp);
    @(negedge clk);
    drive_idle();

    // ---------------- randomized against the model ----------------
    do_reset();
    m_owner = 0; m_streak = 0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    begin
      bit   i_busy, i_got, l_busy, l_got;
      logic exp_i, exp_l;
      int   ntx;
      i_busy = 0; i_got = 0; l_busy = 0; l_got = 0; ntx = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c != 0) @(negedge clk);
        if (i_got) begin
          i_mem_read = 0; i_busy = 0; i_got = 0;
        end else if (!i_busy && $urandom_range(0, 99) < 35) begin
          i_mem_read = 1; i_mem_address = $urandom & 32'hFFFF_FFFC; i_busy = 1;
        end
        if (l_got) begin
          lsq_mem_read = 0; lsq_mem_write = 0; l_busy = 0; l_got = 0;
        end else if (!l_busy && $urandom_range(0, 99) < 45) begin
          lsq_mem_write       = 1'($urandom_range(0, 1));
          lsq_mem_read        = !lsq_mem_write;
          lsq_mem_address     = $urandom;
          lsq_mem_wdata       = $urandom;
          lsq_mem_byte_enable = 4'($urandom_range(0, 15));
          l_busy = 1;
        end
        mem_resp  = (m_owner != 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
        mem_rdata = $urandom;
        #1;
        exp_i = (m_owner == 1) && mem_resp;
        exp_l = (m_owner == 2) && mem_resp;
        chk("rand_mem_read",  mem_read,     (m_owner != 0) && m_rd);
        chk("rand_mem_write", mem_write,    (m_owner != 0) && m_wr);
        chk("rand_i_resp",    i_mem_resp,   exp_i);
        chk("rand_lsq_resp",  lsq_mem_resp, exp_l);
        if (m_owner != 0) begin
          chk("rand_mem_addr",  mem_address,     m_addr);
          chk("rand_mem_wdata", mem_wdata,       m_wdata);
          chk("rand_mem_be",    mem_byte_enable, m_be);
        end
        if (exp_i || exp_l) begin
          $display("rand txn %0d: owner=%s addr=0x%08h rd=%0b wr=%0b", ntx,
                   (m_owner == 1) ? "I" : "D", m_addr, m_rd, m_wr);
          ntx++;
        end
        if (exp_i) i_got = 1;
        if (exp_l) l_got = 1;

        // model advance at the coming rising edge
        if (m_owner == 0) begin
          if ((lsq_mem_read || lsq_mem_write) && (!i_mem_read || m_streak < 4)) begin
            m_owner = 2;
            m_rd = lsq_mem_read; m_wr = lsq_mem_write;
            m_addr = lsq_mem_address; m_wdata = lsq_mem_wdata; m_be = lsq_mem_byte_enable;
            m_streak = i_mem_read ? ((m_streak >= 4) ? 4 : m_streak + 1) : 0;
          end else if (i_mem_read) begin
            m_owner = 1;
            m_rd = 1; m_wr = 0; m_addr = i_mem_address; m_wdata = '0; m_be = 4'hF;
            m_streak = 0;
          end else begin
            m_streak = 0;
          end
        end else if (mem_resp) begin
          m_owner = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
